// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for the RV64 multi-cycle datapath (optional MEM_TIMEOUT_EN)
module multicycle_ctrl #(
  parameter int INST_W      = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_inst_valid,
  output logic              o_inst_req,
  output logic              o_ir_we,
  input  logic              i_zero,
  output logic              o_alu_src_imm,
  output logic [1:0]        o_alu_op,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic              i_mem_done,
  output logic              o_reg_we,
  output logic              o_wb_sel_mem,
  output logic              o_pc_we,
  output logic              o_pc_sel_br,
  output logic              o_halt,
  output logic              o_illegal,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_inst_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_BR = 7'b1100011,
                         OP_ALUI = 7'b0010011, OP_ALUR = 7'b0110011;
  state_t           r_state;
  logic [6:0]       r_op;
  logic [2:0]       r_f3;
  logic             r_stop;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic w_ld, w_sd, w_br, w_alui, w_alur, w_legal, w_take, w_retire;
  assign w_ld     = r_op == OP_LD;
  assign w_sd     = r_op == OP_SD;
  assign w_br     = r_op == OP_BR;
  assign w_alui   = r_op == OP_ALUI;
  assign w_alur   = r_op == OP_ALUR;
  // only beq (000) and bne (001) are implemented among the branches
  assign w_legal  = w_ld | w_sd | w_alui | w_alur | (w_br & r_f3[2:1] == 2'b00);
  assign w_take   = r_f3[0] ? ~i_zero : i_zero;
  // an instruction retires exactly when the PC is updated
  assign w_retire = (r_state == S_EXEC & w_br) | (r_state == S_MEM & w_sd & i_mem_done) | r_state == S_WB;
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_to;
  logic          r_timeout;
  assign o_timeout = r_timeout;
`else
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end
  assign o_timeout = 1'b0;
`endif
  // state sequencing, opcode latch, sticky flags and retired-instruction count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_f3      <= '0;
      r_stop    <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
`ifdef MEM_TIMEOUT_EN
      r_to      <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: if (i_inst_valid) begin
          r_op    <= i_inst[6:0];
          r_f3    <= i_inst[14:12];
          r_stop  <= &i_inst;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_state <= (r_stop | ~w_legal) ? S_HALT : S_EXEC;
          if (~r_stop & ~w_legal) r_illegal <= 1'b1;
        end
        S_EXEC: begin
          r_state <= w_br ? S_FETCH : (w_ld | w_sd) ? S_MEM : S_WB;
`ifdef MEM_TIMEOUT_EN
          r_to    <= '0;
`endif
        end
        S_MEM: if (i_mem_done) r_state <= w_ld ? S_WB : S_FETCH;
`ifdef MEM_TIMEOUT_EN
        else if (r_to == TO_LAST) begin
          r_state   <= S_HALT;
          r_timeout <= 1'b1;
        end else r_to <= r_to + 1'b1;
`endif
        S_WB:   r_state <= S_FETCH;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_inst_req    = r_state == S_FETCH;
  assign o_ir_we       = r_state == S_FETCH & i_inst_valid;
  assign o_alu_src_imm = r_state == S_EXEC & (w_ld | w_sd | w_alui);
  assign o_alu_op      = r_state != S_EXEC ? 2'b00 : w_br ? 2'b01 : (w_alui | w_alur) ? 2'b10 : 2'b00;
  assign o_mem_rd      = r_state == S_MEM & w_ld;
  assign o_mem_wr      = r_state == S_MEM & w_sd;
  assign o_reg_we      = r_state == S_WB;
  assign o_wb_sel_mem  = r_state == S_WB & w_ld;
  assign o_pc_we       = w_retire;
  assign o_pc_sel_br   = r_state == S_EXEC & w_br & w_take;
  assign o_halt        = r_state == S_HALT;
  assign o_illegal     = r_illegal;
  assign o_inst_cnt    = r_cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the multi-cycle control FSM
module tb_multicycle_ctrl;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_inst_valid = 1'b0, i_zero = 1'b0, i_mem_done = 1'b0;
  logic [31:0] i_inst = '0;
  logic        o_inst_req, o_ir_we, o_alu_src_imm, o_mem_rd, o_mem_wr, o_reg_we, o_wb_sel_mem;
  logic        o_pc_we, o_pc_sel_br, o_halt, o_illegal, o_timeout;
  logic [1:0]  o_alu_op;
  logic [31:0] o_inst_cnt;
  int errors = 0, checks = 0;
  localparam logic [31:0] LD = 32'h0000_3003, SD = 32'h0000_3023, BEQ = 32'h0000_0063,
                          BNE = 32'h0000_1063, RALU = 32'h0000_0033, IALU = 32'h0000_0013;

  multicycle_ctrl #(.INST_W(32), .CNT_W(32), .TIMEOUT_CYC(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .o_inst_req(o_inst_req), .o_ir_we(o_ir_we), .i_zero(i_zero),
    .o_alu_src_imm(o_alu_src_imm), .o_alu_op(o_alu_op), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .i_mem_done(i_mem_done), .o_reg_we(o_reg_we),
    .o_wb_sel_mem(o_wb_sel_mem), .o_pc_we(o_pc_we), .o_pc_sel_br(o_pc_sel_br),
    .o_halt(o_halt), .o_illegal(o_illegal), .o_timeout(o_timeout), .o_inst_cnt(o_inst_cnt));

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // from a FETCH cycle: present the instruction, then advance through DECODE to the following state
  task automatic to_exec(input logic [31:0] ins);
    i_inst = ins;
    i_inst_valid = 1'b1;
    #1;
    chk("fetch_req", o_inst_req, 1);
    chk("ir_we", o_ir_we, 1);
    tick;
    i_inst_valid = 1'b0;
    #1;
    chk("decode_ir_we", o_ir_we, 0);
    tick;
  endtask

  // hold reset for two edges, release, and step into FETCH
  task automatic do_reset;
    i_rst = 1'b1;
    tick;
    tick;
    i_rst = 1'b0;
    #1;
    tick;
  endtask

  task automatic run_alu(input logic [31:0] ins, input logic imm, input logic [31:0] cnt);
    to_exec(ins);
    chk("alu_src_imm", o_alu_src_imm, imm);
    chk("alu_op_f", o_alu_op, 2'b10);
    tick;
    chk("alu_reg_we", o_reg_we, 1);
    chk("alu_wb_sel", o_wb_sel_mem, 0);
    chk("alu_pc_we", o_pc_we, 1);
    tick;
    chk("alu_cnt", o_inst_cnt, cnt);
  endtask

  initial begin
    int n;
    logic any_we;
    // reset state
    tick;
    tick;
    chk("rst_cnt", o_inst_cnt, 0);
    chk("rst_halt", o_halt, 0);
    chk("rst_illegal", o_illegal, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_req", o_inst_req, 0);
    chk("rst_pc_we", o_pc_we, 0);
    i_rst = 1'b0;
    #1;
    chk("idle_req", o_inst_req, 0);
    tick;
    chk("c1_req", o_inst_req, 1);
    chk("c1_ir_we", o_ir_we, 0);
    tick;
    // ld, zero-wait memory
    to_exec(LD);
    chk("ld_src_imm", o_alu_src_imm, 1);
    chk("ld_alu_op", o_alu_op, 2'b00);
    chk("ld_exec_rd", o_mem_rd, 0);
    tick;
    i_mem_done = 1'b1;
    #1;
    chk("ld_mem_rd", o_mem_rd, 1);
    chk("ld_mem_pc_we", o_pc_we, 0);
    tick;
    i_mem_done = 1'b0;
    #1;
    chk("ld_wb_rd", o_mem_rd, 0);
    chk("ld_reg_we", o_reg_we, 1);
    chk("ld_wb_sel", o_wb_sel_mem, 1);
    chk("ld_pc_we", o_pc_we, 1);
    chk("ld_pc_sel", o_pc_sel_br, 0);
    chk("ld_wb_req", o_inst_req, 0);
    chk("ld_wb_cnt", o_inst_cnt, 0);
    tick;
    chk("ld_refetch", o_inst_req, 1);
    chk("ld_cnt", o_inst_cnt, 1);
    // beq taken, then bne not taken, both with zero=1
    to_exec(BEQ);
    i_zero = 1'b1;
    #1;
    chk("beq_pc_we", o_pc_we, 1);
    chk("beq_sel", o_pc_sel_br, 1);
    chk("beq_alu_op", o_alu_op, 2'b01);
    chk("beq_src_imm", o_alu_src_imm, 0);
    chk("beq_reg_we", o_reg_we, 0);
    tick;
    chk("beq_cnt", o_inst_cnt, 2);
    chk("beq_refetch", o_inst_req, 1);
    to_exec(BNE);
    chk("bne_pc_we", o_pc_we, 1);
    chk("bne_sel", o_pc_sel_br, 0);
    chk("bne_reg_we", o_reg_we, 0);
    tick;
    i_zero = 1'b0;
    chk("bne_cnt", o_inst_cnt, 3);
    // sd with three wait cycles
    to_exec(SD);
    chk("sd_src_imm", o_alu_src_imm, 1);
    chk("sd_alu_op", o_alu_op, 2'b00);
    tick;
    n = 0;
    any_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_mem_done = (k == 3);
      #1;
      n += int'(o_mem_wr);
      any_we |= o_reg_we;
      if (k < 3) chk("sd_wait_pc_we", o_pc_we, 0);
      else begin
        chk("sd_done_pc_we", o_pc_we, 1);
        chk("sd_done_sel", o_pc_sel_br, 0);
      end
      tick;
    end
    i_mem_done = 1'b0;
    #1;
    chk("sd_wr_cycles", n, 4);
    chk("sd_wr_after", o_mem_wr, 0);
    chk("sd_no_reg_we", any_we, 0);
    chk("sd_cnt", o_inst_cnt, 4);
    chk("sd_refetch", o_inst_req, 1);
    run_alu(RALU, 1'b0, 5);
    run_alu(IALU, 1'b1, 6);
    // reset during MEM of ld
    to_exec(LD);
    tick;
    chk("rmem_rd", o_mem_rd, 1);
    i_rst = 1'b1;
    tick;
    chk("rmem_rd_drop", o_mem_rd, 0);
    chk("rmem_cnt", o_inst_cnt, 0);
    chk("rmem_req", o_inst_req, 0);
    chk("rmem_reg_we", o_reg_we, 0);
    i_rst = 1'b0;
    #1;
    chk("rmem_idle", o_inst_req, 0);
    tick;
    chk("rmem_fetch", o_inst_req, 1);
    // unsupported opcode
    to_exec(32'h0000_0037);
    chk("ill_halt", o_halt, 1);
    chk("ill_flag", o_illegal, 1);
    i_inst_valid = 1'b1;
    i_mem_done = 1'b1;
    repeat (3) tick;
    chk("ill_hold_halt", o_halt, 1);
    chk("ill_hold_flag", o_illegal, 1);
    chk("ill_hold_req", o_inst_req, 0);
    chk("ill_hold_cnt", o_inst_cnt, 0);
    i_inst_valid = 1'b0;
    i_mem_done = 1'b0;
    i_rst = 1'b1;
    tick;
    chk("ill_rst_flag", o_illegal, 0);
    chk("ill_rst_halt", o_halt, 0);
    i_rst = 1'b0;
    #1;
    tick;
    // stop word after one retired instruction
    run_alu(RALU, 1'b0, 1);
    to_exec(32'hFFFF_FFFF);
    repeat (3) tick;
    chk("stop_halt", o_halt, 1);
    chk("stop_illegal", o_illegal, 0);
    chk("stop_cnt", o_inst_cnt, 1);
    chk("stop_pc_we", o_pc_we, 0);
    // branch with unsupported funct3
    do_reset;
    to_exec(32'h0000_2063);
    chk("badbr_halt", o_halt, 1);
    chk("badbr_flag", o_illegal, 1);
    do_reset;
`ifdef MEM_TIMEOUT_EN
    to_exec(LD);
    tick;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      n += int'(o_mem_rd);
      tick;
    end
    chk("to_rd_cycles", n, 4);
    chk("to_flag", o_timeout, 1);
    chk("to_halt", o_halt, 1);
    chk("to_cnt", o_inst_cnt, 0);
    chk("to_reg_we", o_reg_we, 0);
`else
    to_exec(LD);
    tick;
    repeat (8) tick;
    chk("nto_rd_held", o_mem_rd, 1);
    chk("nto_flag", o_timeout, 0);
    chk("nto_halt", o_halt, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
